// File: rtl/zion_pipe_ctrl_pkg.sv
// Shared types and constants for the zion pipeline flush controller.
// Holds the FSM state type and the statistics counter width.
package zion_pipe_ctrl_pkg;
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  localparam int STAT_W = 16;
  localparam int CNT_W  = 8;
endpackage

// File: rtl/zion_pipe_flush_ctrl_dff.sv
// Register bank with async reset, sync clear and load enable.
// Reset and clear both return the bank to INI_DATA.
module ZionBasicCircuitLib_ClrRapDff #(
  parameter int               WIDTH    = 1,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iClr,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      oQ <= INI_DATA;
    else if (iClr)
      oQ <= INI_DATA;
    else if (iEn)
      oQ <= iD;
  end
endmodule

// File: rtl/zion_pipe_flush_ctrl.sv
// Valid/ready pipeline sequencer with flush and stage-clear sequencing.
// Optional statistics counters under ZION_PIPE_FLUSH_CTRL_STAT_EN.
module zion_pipe_flush_ctrl
  import zion_pipe_ctrl_pkg::*;
#(
  parameter int STAGES    = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iInVld,
  output logic                       oInRdy,
  output logic                       oOutVld,
  input  logic                       iOutRdy,
  input  logic                       iFlush,
  output logic [STAGES-1:0]          oStgEn,
  output logic [STAGES-1:0]          oStgClr,
  output logic [$clog2(STAGES+1)-1:0] oOcc,
`ifdef ZION_PIPE_FLUSH_CTRL_STAT_EN
  output logic [STAT_W-1:0]          oFlushCnt,
  output logic [STAT_W-1:0]          oStallCnt,
`endif
  output logic                       oBusy
);
  localparam int OW = $clog2(STAGES+1);
  localparam logic [CNT_W-1:0] CNT_INI = CNT_W'(FLUSH_CYC-1);

  if (STAGES < 1 || FLUSH_CYC < 1) begin : g_param_err
    initial begin
      $error("zion_pipe_flush_ctrl: illegal STAGES or FLUSH_CYC");
`ifdef CHECK_ERR_EXIT
      $finish;
`endif
    end
  end

  state_e             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [STAGES-1:0]  w_vld, w_vld_nxt;
  logic [STAGES:0]    w_rdy;
  logic               w_flush_run;
  logic               w_clr;
  logic [OW-1:0]      w_occ;

  assign w_flush_run = (r_state == RUN) && iFlush;
  assign w_clr       = w_flush_run || (r_state == FLUSH);

  // running variable keeps the chain free of vector self-dependence
  always_comb begin
    logic w_acc;
    w_acc = iOutRdy;
    w_rdy[STAGES] = iOutRdy;
    for (int i = STAGES-1; i >= 0; i--) begin
      w_acc = !w_vld[i] || w_acc;
      w_rdy[i] = w_acc;
    end
  end

  always_comb begin
    w_vld_nxt[0] = w_rdy[0] ? iInVld : w_vld[0];
    for (int i = 1; i < STAGES; i++)
      w_vld_nxt[i] = w_rdy[i] ? w_vld[i-1] : w_vld[i];
  end

  ZionBasicCircuitLib_ClrRapDff #(
    .WIDTH    (STAGES),
    .INI_DATA ('0)
  ) u_vld (
    .clk  (clk),
    .rst  (rst),
    .iClr (w_clr),
    .iEn  (1'b1),
    .iD   (w_vld_nxt),
    .oQ   (w_vld)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= FLUSH;
      r_cnt   <= CNT_INI;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (iFlush) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = CNT_INI;
        end
      end
      FLUSH: begin
        if (iFlush)
          w_cnt_nxt = CNT_INI;
        else if (r_cnt == '0)
          w_state_nxt = RUN;
        else
          w_cnt_nxt = r_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    oInRdy  = 1'b0;
    oOutVld = 1'b0;
    oStgEn  = '0;
    oStgClr = '1;
    oBusy   = (r_state == FLUSH);
    if (r_state == RUN && !iFlush) begin
      oInRdy  = w_rdy[0];
      oOutVld = w_vld[STAGES-1];
      oStgEn  = w_rdy[STAGES-1:0];
      oStgClr = '0;
    end
  end

  always_comb begin
    w_occ = '0;
    for (int i = 0; i < STAGES; i++)
      w_occ = w_occ + OW'(w_vld[i]);
  end
  assign oOcc = w_occ;

`ifdef ZION_PIPE_FLUSH_CTRL_STAT_EN
  logic [STAT_W-1:0] r_flush_cnt;
  logic [STAT_W-1:0] r_stall_cnt;
  localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flush_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_flush_run && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + ONE;
      if (oOutVld && !iOutRdy && r_stall_cnt != '1)
        r_stall_cnt <= r_stall_cnt + ONE;
    end
  end
  assign oFlushCnt = r_flush_cnt;
  assign oStallCnt = r_stall_cnt;
`endif
endmodule
